// File: rtl/axi_stream_downsizing.sv
// -----------------------------------------------------------------------------
// axi_stream_downsizing
//
// Purpose: splits each wide AXI-stream beat into 2^(IEW-OEW) narrower slices.
// Slices whose keep is all zero are skipped. A last beat with no kept bytes
// still produces one null slice (keep=0, last=1), so the packet boundary
// reaches the downstream side. A beat with no kept bytes and no last is
// dropped. The outputs are registered, and the slave side can accept the next
// beat on the same edge that the final pending slice moves to the output.
//
// Ports:
//   clk, rstn        - clock (rising edge) and asynchronous active-low reset
//   i_tvalid/i_tready/i_tdata/i_tkeep/i_tlast
//                    - slave stream, 8<<IEW data bits, 1<<IEW keep bits
//   o_tvalid/o_tready/o_tdata/o_tkeep/o_tlast
//                    - master stream, 8<<OEW data bits, 1<<OEW keep bits
// Parameters:
//   IEW, OEW         - width codes (0=1 byte, 1=2, 2=4, ...); IEW > OEW
// -----------------------------------------------------------------------------
module axi_stream_downsizing #(
  parameter int IEW = 2,
  parameter int OEW = 0
) (
  input  logic                  rstn,
  input  logic                  clk,
  output logic                  i_tready,
  input  logic                  i_tvalid,
  input  logic [(8<<IEW)-1:0]   i_tdata,
  input  logic [(1<<IEW)-1:0]   i_tkeep,
  input  logic                  i_tlast,
  input  logic                  o_tready,
  output logic                  o_tvalid,
  output logic [(8<<OEW)-1:0]   o_tdata,
  output logic [(1<<OEW)-1:0]   o_tkeep,
  output logic                  o_tlast
);

  localparam int N    = 1 << (IEW - OEW);  // slices per input beat
  localparam int SW   = 8 << OEW;          // data bits per slice
  localparam int KW   = 1 << OEW;          // keep bits per slice
  localparam int IDXW = IEW - OEW;         // slice index width

  localparam logic [N-1:0] ONE_N  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] ZERO_N = {N{1'b0}};

  // Buffered beat and the slices of it not yet sent
  logic [(8<<IEW)-1:0] buf_data_r;
  logic [(1<<IEW)-1:0] buf_keep_r;
  logic                buf_last_r;
  logic [N-1:0]        pend_r;

  logic [N-1:0]        raw_mask_s;
  logic [N-1:0]        in_mask_s;
  logic [N-1:0]        low_oh_s;
  logic [IDXW-1:0]     low_idx_s;
  logic                any_pend_s;
  logic                one_pend_s;
  logic                out_free_s;
  logic                load_s;
  logic                accept_s;
  logic [SW-1:0]       sel_data_s;
  logic [KW-1:0]       sel_keep_s;

  // Slice-occupancy mask of the incoming beat
  always_comb begin
    raw_mask_s = ZERO_N;
    for (int k = 0; k < N; k++) begin
      raw_mask_s[k] = |i_tkeep[k*KW +: KW];
    end
  end

  // An all-null last beat still sends slice 0 to carry the packet end
  always_comb begin
    if (i_tlast && (raw_mask_s == ZERO_N)) begin
      in_mask_s = ONE_N;
    end else begin
      in_mask_s = raw_mask_s;
    end
  end

  // Lowest pending slice: one-hot form and binary index
  always_comb begin
    low_oh_s  = pend_r & (~pend_r + ONE_N);
    low_idx_s = {IDXW{1'b0}};
    for (int k = N - 1; k >= 0; k--) begin
      low_idx_s = pend_r[k] ? IDXW'(k) : low_idx_s;
    end
  end

  // Handshake qualifiers; the lowest pending slice is also the highest when
  // it is the only one left, which is where tlast belongs
  always_comb begin
    any_pend_s = (pend_r != ZERO_N);
    one_pend_s = any_pend_s && ((pend_r & ~low_oh_s) == ZERO_N);
    out_free_s = o_tready | ~o_tvalid;
    load_s     = out_free_s & any_pend_s;
    i_tready   = ~any_pend_s | (one_pend_s & out_free_s);
    accept_s   = i_tvalid & i_tready;
    sel_data_s = buf_data_r[low_idx_s*SW +: SW];
    sel_keep_s = buf_keep_r[low_idx_s*KW +: KW];
  end

  // Beat buffer: a new beat overwrites the buffer; otherwise clear the slice
  // just moved to the output
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      buf_data_r <= {(8<<IEW){1'b0}};
      buf_keep_r <= {(1<<IEW){1'b0}};
      buf_last_r <= 1'b0;
      pend_r     <= ZERO_N;
    end else if (accept_s) begin
      buf_data_r <= i_tdata;
      buf_keep_r <= i_tkeep;
      buf_last_r <= i_tlast;
      pend_r     <= in_mask_s;
    end else if (load_s) begin
      pend_r     <= pend_r & ~low_oh_s;
    end else begin
      pend_r     <= pend_r;
    end
  end

  // Output register: loads when free and something is pending, held under stall
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_tvalid <= 1'b0;
      o_tdata  <= {SW{1'b0}};
      o_tkeep  <= {KW{1'b0}};
      o_tlast  <= 1'b0;
    end else if (load_s) begin
      o_tvalid <= 1'b1;
      o_tdata  <= sel_data_s;
      o_tkeep  <= sel_keep_s;
      o_tlast  <= buf_last_r & one_pend_s;
    end else if (out_free_s) begin
      o_tvalid <= 1'b0;
    end else begin
      o_tvalid <= o_tvalid;
    end
  end

endmodule

// File: tb/tb_axi_stream_downsizing.sv
// -----------------------------------------------------------------------------
// tb_axi_stream_downsizing
//
// Self-checking bench for axi_stream_downsizing with IEW=2, OEW=0. A
// negedge monitor keeps a queue of expected output bytes, built from each
// accepted input beat. While o_tvalid is high, every output cycle is compared
// against the head of that queue. Directed scenarios add timing, reset and
// throughput checks. A randomized phase adds backpressure.
// -----------------------------------------------------------------------------
module tb_axi_stream_downsizing;

  logic        clk;
  logic        rstn;
  logic        i_tready;
  logic        i_tvalid;
  logic [31:0] i_tdata;
  logic [3:0]  i_tkeep;
  logic        i_tlast;
  logic        o_tready;
  logic        o_tvalid;
  logic [7:0]  o_tdata;
  logic [0:0]  o_tkeep;
  logic        o_tlast;

  int n_checks;
  int n_errors;
  int exp_lasts;
  int obs_lasts;
  int n_out;

  // Expected output slices: {data[7:0], keep, last}
  logic [9:0] exp_q[$];

  axi_stream_downsizing #(.IEW(2), .OEW(0)) dut (
    .rstn     (rstn),
    .clk      (clk),
    .i_tready (i_tready),
    .i_tvalid (i_tvalid),
    .i_tdata  (i_tdata),
    .i_tkeep  (i_tkeep),
    .i_tlast  (i_tlast),
    .o_tready (o_tready),
    .o_tvalid (o_tvalid),
    .o_tdata  (o_tdata),
    .o_tkeep  (o_tkeep),
    .o_tlast  (o_tlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: the kept bytes in lane order. last goes on the final kept
  // byte, or on a null byte-0 slice if the last beat keeps nothing.
  task automatic model_push(input logic [31:0] d, input logic [3:0] k, input logic l);
    int n;
    logic [9:0] e;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (k[i]) begin
        exp_q.push_back({d[i*8 +: 8], 1'b1, 1'b0});
        n++;
      end
    end
    if (l) begin
      exp_lasts++;
      if (n == 0) begin
        exp_q.push_back({d[7:0], 1'b0, 1'b1});
      end else begin
        e = exp_q.pop_back();
        e[0] = 1'b1;
        exp_q.push_back(e);
      end
    end
  endtask

  // Monitor: values seen at the negedge are the ones the next posedge acts on
  always @(negedge clk) begin
    logic [9:0] e;
    if (!rstn) begin
      exp_q.delete();
    end else begin
      if (o_tvalid) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_out", 64'd1, 64'd0);
        end else begin
          e = exp_q[0];
          check_eq("out_data", {56'd0, o_tdata}, {56'd0, e[9:2]});
          check_eq("out_keep", {63'd0, o_tkeep}, {63'd0, e[1]});
          check_eq("out_last", {63'd0, o_tlast}, {63'd0, e[0]});
          if (o_tready) begin
            void'(exp_q.pop_front());
            n_out++;
            if (o_tlast) obs_lasts++;
          end
        end
      end
      if (i_tvalid && i_tready) begin
        model_push(i_tdata, i_tkeep, i_tlast);
      end
    end
  end

  // Present one beat and hold it until accepted; returns 1 ns after the accept edge
  task automatic drive_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    logic done;
    done = 1'b0;
    i_tvalid = 1'b1;
    i_tdata  = d;
    i_tkeep  = k;
    i_tlast  = l;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      if (i_tready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    i_tvalid = 1'b0;
    if (!done) check_eq("drive_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int rdy_cnt;
    int val_cnt;
    int sent;
    int out_before;
    logic hs;
    logic done;

    n_checks  = 0;
    n_errors  = 0;
    exp_lasts = 0;
    obs_lasts = 0;
    n_out     = 0;
    rstn      = 1'b0;
    i_tvalid  = 1'b0;
    i_tdata   = 32'd0;
    i_tkeep   = 4'd0;
    i_tlast   = 1'b0;
    o_tready  = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_tvalid", {63'd0, o_tvalid}, 64'd0);
    check_eq("rst_tdata",  {56'd0, o_tdata},  64'd0);
    check_eq("rst_tkeep",  {63'd0, o_tkeep},  64'd0);
    check_eq("rst_tlast",  {63'd0, o_tlast},  64'd0);
    check_eq("rst_tready", {63'd0, i_tready}, 64'd1);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    idle(2);

    // Scenario 1: full beat, one-cycle latency, four bytes in order
    drive_beat(32'h44332211, 4'b1111, 1'b1);
    @(negedge clk);
    check_eq("s1_latency", {63'd0, o_tvalid}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("s1_valid", {63'd0, o_tvalid}, 64'd1);
      check_eq("s1_data",  {56'd0, o_tdata},  64'h11 * (i + 1));
      check_eq("s1_last",  {63'd0, o_tlast},  (i == 3) ? 64'd1 : 64'd0);
    end
    @(negedge clk);
    check_eq("s1_idle", {63'd0, o_tvalid}, 64'd0);
    idle(2);

    // Scenario 2: sparse keep skips null lanes
    drive_beat(32'hAABBCCDD, 4'b0101, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check_eq("s2_data0", {56'd0, o_tdata}, 64'hDD);
    check_eq("s2_last0", {63'd0, o_tlast}, 64'd0);
    @(negedge clk);
    check_eq("s2_data1", {56'd0, o_tdata}, 64'hBB);
    check_eq("s2_last1", {63'd0, o_tlast}, 64'd1);
    @(negedge clk);
    check_eq("s2_idle", {63'd0, o_tvalid}, 64'd0);
    idle(2);

    // Scenario 3: null non-last beat dropped; null last beat gives one marker slice
    drive_beat(32'h01020304, 4'b0000, 1'b0);
    @(negedge clk);
    check_eq("s3_ready", {63'd0, i_tready}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("s3_nooutput", {63'd0, o_tvalid}, 64'd0);
    end
    idle(1);
    drive_beat(32'h12345678, 4'b0000, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check_eq("s3_null_valid", {63'd0, o_tvalid}, 64'd1);
    check_eq("s3_null_keep",  {63'd0, o_tkeep},  64'd0);
    check_eq("s3_null_last",  {63'd0, o_tlast},  64'd1);
    idle(3);

    // Scenario 4: back-to-back full beats, no bubbles, i_tready 1 in 4
    rdy_cnt  = 0;
    val_cnt  = 0;
    i_tvalid = 1'b1;
    i_tkeep  = 4'b1111;
    i_tlast  = 1'b0;
    i_tdata  = $urandom;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      hs = i_tready;
      if (c >= 8) begin
        rdy_cnt += int'(i_tready);
        val_cnt += int'(o_tvalid);
      end
      @(posedge clk);
      #1;
      if (hs) i_tdata = $urandom;
    end
    i_tvalid = 1'b0;
    check_eq("s4_valid_cycles", 64'(val_cnt), 64'd32);
    check_eq("s4_ready_cycles", 64'(rdy_cnt), 64'd8);
    idle(8);
    check_eq("s4_drained", 64'(exp_q.size()), 64'd0);

    // Scenario 5: 1000 random beats under random backpressure
    sent = 0;
    done = 1'b0;
    for (int c = 0; c < 30000 && !done; c++) begin
      o_tready = ($urandom_range(0, 9) < 7);
      if (!i_tvalid && sent < 1000 && $urandom_range(0, 3) != 0) begin
        i_tvalid = 1'b1;
        i_tdata  = $urandom;
        i_tkeep  = ($urandom_range(0, 3) == 0) ? 4'b1111 : 4'($urandom_range(0, 15));
        i_tlast  = ($urandom_range(0, 3) == 0);
      end
      @(negedge clk);
      hs = i_tvalid & i_tready;
      @(posedge clk);
      #1;
      if (hs) begin
        i_tvalid = 1'b0;
        sent++;
      end
      done = (sent == 1000) && (exp_q.size() == 0) && !o_tvalid;
    end
    o_tready = 1'b1;
    check_eq("s5_beats_sent", 64'(sent), 64'd1000);
    check_eq("s5_drained", 64'(exp_q.size()), 64'd0);
    check_eq("s5_tlast_count", 64'(obs_lasts), 64'(exp_lasts));
    idle(2);

    // Scenario 6: reset after two of four slices have been sent
    drive_beat(32'h44332211, 4'b1111, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check_eq("s6_first", {56'd0, o_tdata}, 64'h11);
    @(negedge clk);
    check_eq("s6_second", {56'd0, o_tdata}, 64'h22);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    check_eq("s6_rst_valid", {63'd0, o_tvalid}, 64'd0);
    check_eq("s6_rst_data",  {56'd0, o_tdata},  64'd0);
    check_eq("s6_rst_keep",  {63'd0, o_tkeep},  64'd0);
    check_eq("s6_rst_last",  {63'd0, o_tlast},  64'd0);
    check_eq("s6_rst_ready", {63'd0, i_tready}, 64'd1);
    idle(2);
    rstn = 1'b1;
    idle(1);
    out_before = n_out;
    drive_beat(32'hDDCCBBAA, 4'b0011, 1'b1);
    idle(6);
    check_eq("s6_new_count", 64'(n_out - out_before), 64'd2);
    check_eq("s6_drained", 64'(exp_q.size()), 64'd0);
    check_eq("s6_idle", {63'd0, o_tvalid}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
